// File: rtl/ad_ip_jesd204_tpl_profile_seq_pkg.sv
// Shared state encoding and timer sizing helper for the TPL profile sequencer.
package ad_ip_jesd204_tpl_profile_seq_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t StIdle     = 2'd0;
  localparam seq_state_t StHoldRst  = 2'd1;
  localparam seq_state_t StSettle   = 2'd2;
  localparam seq_state_t StWaitSync = 2'd3;

  // Width holding max(a, b, c) - 1, never narrower than one bit.
  function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = unsigned'($clog2(m));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ad_tpl_seq_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module ad_tpl_seq_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          up_clk,
  input  logic          up_rstn,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ad_ip_jesd204_tpl_profile_seq.sv
// Safe JESD profile switch: hold datapath reset, swap profile, settle, release, await sync.
// Define AD_TPL_PROFILE_SEQ_TIMEOUT_EN to bound the sync wait and enable err_timeout.
module ad_ip_jesd204_tpl_profile_seq
  import ad_ip_jesd204_tpl_profile_seq_pkg::*;
#(
  parameter  int unsigned NUM_PROFILES   = 1,
  parameter  int unsigned RST_CYCLES     = 16,
  parameter  int unsigned SETTLE_CYCLES  = 8,
  parameter  int unsigned TIMEOUT_CYCLES = 65536,
  localparam int unsigned PW             = $clog2(NUM_PROFILES) + 1
) (
  input  logic          up_clk,
  input  logic          up_rstn,
  input  logic          req_valid,
  input  logic [PW-1:0] req_profile,
  output logic          req_ready,
  input  logic          sync_status,
  output logic [PW-1:0] profile_sel,
  output logic          dp_rst,
  output logic          busy,
  output logic          done,
  output logic          err_invalid,
  output logic          err_timeout
);

`ifdef AD_TPL_PROFILE_SEQ_TIMEOUT_EN
  localparam bit          TimeoutEn  = 1'b1;
  localparam int unsigned TimeoutLen = TIMEOUT_CYCLES;
`else
  localparam bit          TimeoutEn  = 1'b0;
  localparam int unsigned TimeoutLen = 1;
`endif

  localparam int unsigned   TW         = tmr_width(RST_CYCLES, SETTLE_CYCLES, TimeoutLen);
  localparam logic [PW-1:0] MaxProfile = PW'(NUM_PROFILES - 1);

  seq_state_t    state_q, state_d;
  logic [PW-1:0] prof_req_q, prof_req_d;
  logic [PW-1:0] profile_sel_q, profile_sel_d;
  logic          dp_rst_q, dp_rst_d;
  logic          busy_q, busy_d;
  logic          req_ready_q, req_ready_d;
  logic          done_q, done_d;
  logic          err_invalid_q, err_invalid_d;
  logic          err_timeout_q, err_timeout_d;

  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          accept, prof_ok;

  assign accept  = req_valid && req_ready_q;
  assign prof_ok = (req_profile <= MaxProfile);

  ad_tpl_seq_timer #(
    .TW (TW)
  ) u_timer (
    .up_clk   (up_clk),
    .up_rstn  (up_rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q       <= StIdle;
      prof_req_q    <= '0;
      profile_sel_q <= '0;
      dp_rst_q      <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= 1'b1;
      done_q        <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prof_req_q    <= prof_req_d;
      profile_sel_q <= profile_sel_d;
      dp_rst_q      <= dp_rst_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      done_q        <= done_d;
      err_invalid_q <= err_invalid_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept && prof_ok) state_d = StHoldRst;
      StHoldRst:  if (tmr_zero) state_d = StSettle;
      StSettle:   if (tmr_zero) state_d = StWaitSync;
      StWaitSync: if (sync_status || (TimeoutEn && tmr_zero)) state_d = StIdle;
    endcase
  end

  always_comb begin
    prof_req_d    = prof_req_q;
    profile_sel_d = profile_sel_q;
    dp_rst_d      = dp_rst_q;
    done_d        = 1'b0;
    err_invalid_d = 1'b0;
    err_timeout_d = err_timeout_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    tmr_en        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && prof_ok) begin
          prof_req_d    = req_profile;
          dp_rst_d      = 1'b1;
          err_timeout_d = 1'b0;
          tmr_load      = 1'b1;
          tmr_val       = TW'(RST_CYCLES - 1);
        end else if (accept) begin
          err_invalid_d = 1'b1;
        end
      end
      StHoldRst: begin
        if (tmr_zero) begin
          profile_sel_d = prof_req_q;
          tmr_load      = 1'b1;
          tmr_val       = TW'(SETTLE_CYCLES - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      StSettle: begin
        if (tmr_zero) begin
          dp_rst_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TW'(TimeoutLen - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      StWaitSync: begin
        // Sync seen in the last timeout cycle still counts as success.
        if (sync_status) begin
          done_d = 1'b1;
        end else if (TimeoutEn && tmr_zero) begin
          err_timeout_d = 1'b1;
        end else begin
          tmr_en = TimeoutEn;
        end
      end
    endcase
    busy_d      = (state_d != StIdle);
    req_ready_d = (state_d == StIdle);
  end

  assign req_ready   = req_ready_q;
  assign profile_sel = profile_sel_q;
  assign dp_rst      = dp_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_invalid = err_invalid_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/ad_ip_jesd204_tpl_profile_seq.md
# ad_ip_jesd204_tpl_profile_seq

The profile sequencer performs a safe JESD profile switch for the TPL ADC datapath. It accepts a profile-change request, holds the datapath in reset, updates the profile select, waits for settling, then releases reset. It completes once link sync status is reported. It sits between the register map and the TPL deframer/datapath, and is the single owner of the datapath profile select and its sequencing reset.

## Interface
Parameters:
- `NUM_PROFILES`, 1: number of supported JESD profiles; `PW = $clog2(NUM_PROFILES)+1`.
- `RST_CYCLES`, 16: cycles the datapath reset is held before the profile change; min 1.
- `SETTLE_CYCLES`, 8: cycles reset stays held after the profile change; min 1.
- `TIMEOUT_CYCLES`, 65536: maximum cycles spent waiting for sync; min 1. Used only with the timeout feature.

Ports (one clock; reset is asynchronous and active-low):
- `up_clk` in 1: single clock for all logic.
- `up_rstn` in 1: asynchronous active-low reset.
- `req_valid` in 1: profile-change request.
- `req_profile` in PW: requested profile index.
- `req_ready` out 1: high only in IDLE.
- `sync_status` in 1: link sync, already synchronized to `up_clk`.
- `profile_sel` out PW: profile select driven to the datapath.
- `dp_rst` out 1: datapath sequencing reset, active-high.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err_invalid` out 1: one-cycle pulse when a request has `req_profile >= NUM_PROFILES`.
- `err_timeout` out 1: sticky; cleared when the next request is accepted.

## Operation
- States: IDLE, HOLD_RST, SETTLE, WAIT_SYNC.
- **Accept:** a request is accepted on an edge where `req_valid && req_ready`.
  - Valid profile: go to HOLD_RST, load the timer with RST_CYCLES-1, set `dp_rst=1`, clear `err_timeout`.
  - Invalid profile: pulse `err_invalid` for one cycle and stay in IDLE. `profile_sel`, `dp_rst` and `err_timeout` do not change.
- **HOLD_RST:** count down. At timer==0, register `profile_sel <= req_profile` (the value captured at accept), load SETTLE_CYCLES-1, go to SETTLE.
- **SETTLE:** `dp_rst` stays 1. At timer==0, clear `dp_rst` and go to WAIT_SYNC.
- **WAIT_SYNC:**
  - `sync_status` sampled high: pulse `done` and go to IDLE.
  - Timeout feature compiled in: if the timer expires first, set `err_timeout` and go to IDLE. `dp_rst` stays 0.
  - If `sync_status` and timer expiry happen in the same cycle, success wins (`done`, no error).
- A request for the current profile runs the full sequence; there is no shortcut.
- `req_valid` while busy is ignored, because `req_ready=0`. `req_profile` is captured only at accept.
- The timer is a single down-counter sized to `$clog2` of the largest of the three cycle parameters.

## Timing
Reset values (applied asynchronously on `up_rstn` low, including mid-sequence):
- State returns to IDLE.
- `profile_sel=0`, `dp_rst=0`, `busy=0`, `req_ready=1`, `done=0`, `err_invalid=0`, `err_timeout=0`, timer=0.

All outputs are registered. Taking the accept edge as the end of cycle 0:
- `dp_rst` is high in cycles 1 .. RST_CYCLES+SETTLE_CYCLES.
- `profile_sel` changes at the start of cycle RST_CYCLES+1.
- WAIT_SYNC begins in cycle RST_CYCLES+SETTLE_CYCLES+1, with `dp_rst=0`.
- With `sync_status` already high, `done` is high in cycle RST_CYCLES+SETTLE_CYCLES+2. `req_ready` returns to 1 in that same cycle.
- Timeout case: WAIT_SYNC lasts exactly TIMEOUT_CYCLES cycles. `err_timeout` rises the cycle after that.
- `err_invalid` is high in cycle 1 only.

## Configuration
- Macro: `AD_TPL_PROFILE_SEQ_TIMEOUT_EN`.
- Defined: WAIT_SYNC uses the timer and can end with `err_timeout`.
- Undefined: WAIT_SYNC waits indefinitely for `sync_status`. `err_timeout` is tied to 0, and the `TIMEOUT_CYCLES` parameter is ignored.

## Structure
- Package `ad_ip_jesd204_tpl_profile_seq_pkg` holds:
  - the state encoding localparams;
  - a timer-width helper function.
- One sub-module, `ad_tpl_seq_timer`: a loadable down-counter with load and zero-flag outputs.
- The FSM and the output registers stay in the top module.

## Test plan
All scenarios use NUM_PROFILES=2, RST_CYCLES=4, SETTLE_CYCLES=2, TIMEOUT_CYCLES=10, timeout feature compiled in.

1. Request profile 1 with `sync_status=1` → `dp_rst` high in cycles 1–6, `profile_sel=1` from cycle 5, `done` high in cycle 8, `req_ready=1` in cycle 8.
2. Request profile 3 → `err_invalid` high in cycle 1; `dp_rst` stays 0, `profile_sel` unchanged, `busy` stays 0.
3. Request with `sync_status=0` throughout → `err_timeout` rises in cycle 17 and stays high. A new valid request clears it in cycle 1.
4. `sync_status` rises in the final timeout cycle (cycle 16) → `done` in cycle 17 and `err_timeout=0`.
5. `up_rstn` pulsed low in cycle 3 → all outputs return to their reset values immediately; the next request then runs the full sequence.
6. `req_valid` held with changing `req_profile` during the sequence → only the first value takes effect; no second sequence starts until `req_ready` is high.
